// File: rtl/vote_pkg.sv
// vote_pkg: candidate codes, capture FSM states and one-hot helper shared with the vote logger.
package vote_pkg;
  localparam logic [3:0] CAND_1 = 4'b0001;
  localparam logic [3:0] CAND_2 = 4'b0010;
  localparam logic [3:0] CAND_3 = 4'b0100;
  localparam logic [3:0] CAND_4 = 4'b1000;
  typedef enum logic [2:0] {IDLE, DEBOUNCE, FIRE, WAIT_RELEASE, LOCKOUT} state_t;
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction
endpackage

// File: rtl/vote_capture_if.sv
// vote_capture_if: mode/button inputs and vote outputs; invalid_press exists only with VOTE_CAPTURE_INVALID_EN.
interface vote_capture_if;
  logic       mode;
  logic [3:0] btn;
  logic       vote_logged;
  logic [3:0] candidate;
  logic       busy;
`ifdef VOTE_CAPTURE_INVALID_EN
  logic       invalid_press;
  modport master (output mode, btn, input vote_logged, candidate, busy, invalid_press);
  modport slave  (input mode, btn, output vote_logged, candidate, busy, invalid_press);
`else
  modport master (output mode, btn, input vote_logged, candidate, busy);
  modport slave  (input mode, btn, output vote_logged, candidate, busy);
`endif
endinterface

// File: rtl/btn_sync.sv
// btn_sync: W-bit two-flop synchroniser, async active-low reset to 0.
module btn_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/vote_capture.sv
// vote_capture: debounced single-vote capture with multi-press reject and post-vote lockout.
// Define VOTE_CAPTURE_INVALID_EN to add the invalid_press pulse.
module vote_capture
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int LOCKOUT_CYCLES  = 100,
  parameter int CNT_W           = 8
) (
  input logic clk,
  input logic reset_all,
  vote_capture_if.slave bus
);
  localparam logic [CNT_W-1:0] DB_END = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LK_END = CNT_W'(LOCKOUT_CYCLES - 1);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       sb, sample, sample_n, cand;
  logic             vote;
  btn_sync #(.W(4)) u_sync (.clk(clk), .rst_n(reset_all), .d(bus.btn), .q(sb));
  assign cnt_inc = &cnt ? cnt : cnt + CNT_W'(1);
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sample_n = sample;
    case (state)
      IDLE:
        if (!bus.mode && sb != 4'd0) begin
          sample_n = sb;
          cnt_n    = CNT_W'(1);
          state_n  = DEBOUNCE;
        end
      DEBOUNCE:
        if (sb != sample || sb == 4'd0) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (bus.mode) begin
          cnt_n   = '0;
          state_n = WAIT_RELEASE;
        end else if (cnt == DB_END) begin
          cnt_n   = '0;
          state_n = is_onehot4(sample) ? FIRE : WAIT_RELEASE;
        end else
          cnt_n = cnt_inc;
      FIRE: begin
        cnt_n   = '0;
        state_n = WAIT_RELEASE;
      end
      WAIT_RELEASE:
        if (sb != 4'd0)
          cnt_n = '0;
        else if (cnt == DB_END) begin
          cnt_n   = '0;
          state_n = LOCKOUT;
        end else
          cnt_n = cnt_inc;
      LOCKOUT:
        if (cnt == LK_END) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else
          cnt_n = cnt_inc;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_all)
    if (!reset_all) begin
      state  <= IDLE;
      cnt    <= '0;
      sample <= '0;
      vote   <= 1'b0;
      cand   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sample <= sample_n;
      vote   <= state_n == FIRE;
      cand   <= state_n == FIRE ? sample : cand;
    end
  assign bus.vote_logged = vote;
  assign bus.candidate   = cand;
  assign bus.busy        = state != IDLE;
`ifdef VOTE_CAPTURE_INVALID_EN
  logic inv;
  // With mode low, DEBOUNCE only falls into WAIT_RELEASE on a completed non-one-hot count.
  always_ff @(posedge clk or negedge reset_all)
    if (!reset_all) inv <= 1'b0;
    else inv <= state == DEBOUNCE && state_n == WAIT_RELEASE && !bus.mode;
  assign bus.invalid_press = inv;
`endif
endmodule
